// File: rtl/ooo_rr_issue_arbiter_pkg.sv
// Shared types and helpers for the round-robin issue arbiter.
package ooo_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ooo_rr_issue_arbiter_pick.sv
// Round-robin one-hot pick: lowest request strictly above ptr_i, else lowest request overall.
module ooo_rr_pick
  import ooo_arb_pkg::*;
#(
  parameter int els_p        = 4,
  parameter int tag_width_lp = tag_width(els_p)
) (
  input  logic [els_p-1:0]        req_i,
  input  logic [tag_width_lp-1:0] ptr_i,
  output logic [els_p-1:0]        pick_o,
  output logic                    any_o
);

  logic [els_p-1:0] hi_mask;
  logic [els_p-1:0] hi;
  logic [els_p-1:0] hi_pick;
  logic [els_p-1:0] lo_pick;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    hi_mask = '0;
    for (int i = 0; i < els_p; i++) begin
      hi_mask[i] = (i > int'(ptr_i));
    end
  end

  // x & -x isolates the lowest set bit: a low-to-high one-hot priority encode.
  assign hi      = req_i & hi_mask;
  assign hi_pick = hi & (~hi + els_p'(1));
  assign lo_pick = req_i & (~req_i + els_p'(1));

  assign any_o  = |req_i;
  assign pick_o = (|hi) ? hi_pick : lo_pick;

endmodule

// File: rtl/ooo_rr_issue_arbiter.sv
// Round-robin arbiter sharing one FU issue port; holds its grant until ready_i.
// Optional starvation monitor enabled by defining OOO_RR_ARB_STARVE_CHECK_EN.
module ooo_rr_issue_arbiter
  import ooo_arb_pkg::*;
#(
  parameter  int els_p        = 4,
  localparam int tag_width_lp = tag_width(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [els_p-1:0]        reqs_i,
  output logic                    v_o,
  output logic [els_p-1:0]        grants_o,
  output logic [tag_width_lp-1:0] tag_o,
  input  logic                    ready_i,
  output logic [els_p-1:0]        yumi_o,
  output logic [els_p-1:0]        starve_o
);

  localparam logic [tag_width_lp-1:0] ptr_rst_lp = tag_width_lp'(els_p - 1);

  arb_state_e              state_q;
  logic [els_p-1:0]        grants_q;
  logic [tag_width_lp-1:0] tag_q;
  logic [tag_width_lp-1:0] ptr_q;

  logic [els_p-1:0]        pick_req;
  logic [tag_width_lp-1:0] pick_ptr;
  logic [els_p-1:0]        pick;
  logic                    pick_any;
  logic [tag_width_lp-1:0] pick_tag;
  logic                    accept;

  assign accept = v_o & ready_i;

  // In GRANT the accepted requester is excluded and the search starts after it.
  assign pick_req = (state_q == ARB_GRANT) ? (reqs_i & ~grants_q) : reqs_i;
  assign pick_ptr = (state_q == ARB_GRANT) ? tag_q : ptr_q;

  ooo_rr_pick #(
    .els_p       (els_p),
    .tag_width_lp(tag_width_lp)
  ) u_pick (
    .req_i (pick_req),
    .ptr_i (pick_ptr),
    .pick_o(pick),
    .any_o (pick_any)
  );

  always_comb begin
    pick_tag = '0;
    for (int i = 0; i < els_p; i++) begin
      if (pick[i]) pick_tag = tag_width_lp'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) begin
      state_q  <= ARB_IDLE;
      grants_q <= '0;
      tag_q    <= '0;
      ptr_q    <= ptr_rst_lp;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grants_q <= pick;
            tag_q    <= pick_tag;
            state_q  <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (ready_i) begin
            ptr_q <= tag_q;
            if (pick_any) begin
              grants_q <= pick;
              tag_q    <= pick_tag;
            end else begin
              grants_q <= '0;
              tag_q    <= '0;
              state_q  <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign v_o      = (state_q == ARB_GRANT);
  assign grants_o = grants_q;
  assign tag_o    = tag_q;
  assign yumi_o   = grants_q & {els_p{accept}};

`ifdef OOO_RR_ARB_STARVE_CHECK_EN
  localparam int                  cnt_w_lp   = $clog2(els_p) + 1;
  localparam logic [cnt_w_lp-1:0] cnt_lim_lp = cnt_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(els_p);

  logic [cnt_w_lp-1:0] cnt_q [els_p];
  logic [els_p-1:0]    starve_q;
  logic [els_p-1:0]    starve_set;

  always_comb begin
    starve_set = '0;
    for (int i = 0; i < els_p; i++) begin
      starve_set[i] = reqs_i[i] & ~yumi_o[i] & accept & (cnt_q[i] >= cnt_lim_lp);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any other state.
      for (int i = 0; i < els_p; i++) cnt_q[i] <= '0;
      starve_q <= '0;
    end else begin
      for (int i = 0; i < els_p; i++) begin
        if (!reqs_i[i] || yumi_o[i]) begin
          cnt_q[i] <= '0;
        end else if (accept && (cnt_q[i] < cnt_max_lp)) begin
          cnt_q[i] <= cnt_q[i] + cnt_w_lp'(1);
        end
        if (starve_set[i]) starve_q[i] <= 1'b1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (!reset_i) begin
      assert ((starve_set & ~starve_q) == '0)
        else $error("ooo_rr_issue_arbiter: starvation flag set, starve_set=%b", starve_set);
    end
  end

  assign starve_o = starve_q;
`else
  assign starve_o = '0;
`endif

endmodule

// File: tb/tb_ooo_rr_issue_arbiter.sv
// Self-checking bench for ooo_rr_issue_arbiter: directed steps plus random traffic vs a queue-free RR model.
module tb_ooo_rr_issue_arbiter;

  localparam int N  = 4;
  localparam int TW = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [N-1:0]  reqs_i;
  logic          v_o;
  logic [N-1:0]  grants_o;
  logic [TW-1:0] tag_o;
  logic          ready_i;
  logic [N-1:0]  yumi_o;
  logic [N-1:0]  starve_o;

  int errors = 0;
  int checks = 0;

  // Reference model: granted index (or none) and last-winner pointer.
  bit m_valid;
  int m_tag;
  int m_ptr;

  // DUT outputs observed at the most recent step's check point.
  logic          obs_v;
  logic [N-1:0]  obs_grants;
  logic [TW-1:0] obs_tag;
  logic [N-1:0]  obs_yumi;

  ooo_rr_issue_arbiter #(.els_p(N)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .reqs_i  (reqs_i),
    .v_o     (v_o),
    .grants_o(grants_o),
    .tag_o   (tag_o),
    .ready_i (ready_i),
    .yumi_o  (yumi_o),
    .starve_o(starve_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Circular search starting just after ptr; -1 when nothing requests.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [N-1:0] e_grants;
    logic [N-1:0] e_yumi;
    e_grants = m_valid ? N'(1 << m_tag) : '0;
    e_yumi   = (m_valid && ready_i) ? e_grants : '0;
    check("v_o",      32'(v_o),      32'(m_valid));
    check("grants_o", 32'(grants_o), 32'(e_grants));
    check("tag_o",    32'(tag_o),    m_valid ? 32'(m_tag) : 32'd0);
    check("yumi_o",   32'(yumi_o),   32'(e_yumi));
    check("starve_o", 32'(starve_o), 32'd0);
  endtask

  task automatic model_update();
    if (reset_i) begin
      m_valid = 1'b0;
      m_tag   = 0;
      m_ptr   = N - 1;
    end else if (!m_valid) begin
      if (reqs_i != '0) begin
        m_tag   = rr_pick(reqs_i, m_ptr);
        m_valid = 1'b1;
      end
    end else if (ready_i) begin
      logic [N-1:0] rest;
      m_ptr = m_tag;
      rest  = reqs_i & ~N'(1 << m_tag);
      if (rest != '0) m_tag = rr_pick(rest, m_tag);
      else begin
        m_valid = 1'b0;
        m_tag   = 0;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rdy, input logic rst);
    @(negedge clk_i);
    reqs_i  = r;
    ready_i = rdy;
    reset_i = rst;
    #1;
    obs_v      = v_o;
    obs_grants = grants_o;
    obs_tag    = tag_o;
    obs_yumi   = yumi_o;
    check_outputs();
    @(posedge clk_i);
    model_update();
  endtask

  int           acc_tag[$];
  int           acc_step[$];
  int           cool[N];
  int           yumi_cnt;
  logic [N-1:0] r;
  int           exp_seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    reqs_i  = '0;
    ready_i = 1'b0;
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    model_update();

    // Reset state, then idle with no requests.
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step('0, 1'b1, 1'b0);

    // All four requesting; each drops for one cycle after its yumi.
    for (int i = 0; i < N; i++) cool[i] = 0;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = (cool[i] == 0);
        if (cool[i] > 0) cool[i]--;
      end
      step(r, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) if (obs_yumi[i]) cool[i] = 1;
      if (obs_yumi != '0) begin
        acc_tag.push_back(int'(obs_tag));
        acc_step.push_back(s);
      end
    end
    check("rr_accept_count_ge5", 32'(acc_tag.size() >= 5), 32'd1);
    if (acc_tag.size() >= 5) begin
      check("rr_first_latency", 32'(acc_step[0]), 32'd1);
      for (int k = 0; k < 5; k++) begin
        check("rr_seq_tag",  32'(acc_tag[k]),  32'(exp_seq[k]));
        check("rr_seq_step", 32'(acc_step[k]), 32'(acc_step[0] + k));
      end
    end
    step('0, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    // Grant held while ready_i is low, then handed on to requester 2.
    step('0, 1'b0, 1'b1);
    step(4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0110, 1'b0, 1'b0);
      check("hold_grants", 32'(obs_grants), 32'h2);
      check("hold_yumi",   32'(obs_yumi),   32'h0);
    end
    step(4'b0110, 1'b1, 1'b0);
    check("hold_accept_yumi", 32'(obs_yumi), 32'h2);
    step(4'b0100, 1'b0, 1'b0);
    check("hold_next_grants", 32'(obs_grants), 32'h4);
    check("hold_next_tag",    32'(obs_tag),    32'd2);
    step(4'b0100, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    // Lone requester 3 re-requesting: one idle cycle between grants.
    step('0, 1'b0, 1'b1);
    yumi_cnt = 0;
    for (int s = 0; s < 8; s++) begin
      step(4'b1000, 1'b1, 1'b0);
      check("single_alt_v", 32'(obs_v), 32'(s % 2));
      if (obs_yumi != '0) begin
        yumi_cnt++;
        check("single_tag", 32'(obs_tag), 32'd3);
      end
    end
    check("single_yumi_count", 32'(yumi_cnt), 32'd4);
    step('0, 1'b1, 1'b0);

    // Reset while a grant to requester 3 is pending.
    step('0, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1010, 1'b0, 1'b0);
    check("rst_pending_v", 32'(obs_v), 32'd1);
    step(4'b1010, 1'b0, 1'b1);
    check("rst_no_yumi", 32'(obs_yumi), 32'h0);
    step(4'b1010, 1'b0, 1'b0);
    check("rst_after_v", 32'(obs_v), 32'd0);
    step(4'b1010, 1'b0, 1'b0);
    check("rst_first_grant", 32'(obs_grants), 32'h2);
    step(4'b1010, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    // Random traffic against the model, with occasional resets.
    for (int s = 0; s < 300; s++) begin
      step(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
